// File: rtl/score_render.sv
// Renders the frame-stable BCD score (and optional high score, SCORE_RENDER_HISCORE_EN) as a per-pixel lit bit.
// Fixed 2-cycle latency from hpos/vpos to pixel_on; no stall, accepts a new pixel every cycle.
module score_render #(
    parameter int X0 = 16,
    parameter int Y0 = 16,
    parameter int S  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score,
    input  logic        game_tick,
    input  logic        game_over,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    output logic        pixel_on,
    output logic [15:0] hiscore
);

    localparam logic [10:0] FIELD_W = 11'(16 << S);
    localparam logic [10:0] LINE_H  = 11'(5 << S);
`ifdef SCORE_RENDER_HISCORE_EN
    localparam logic [10:0] HI_TOP  = 11'(6 << S);
    localparam logic [10:0] HI_BOT  = 11'(11 << S);
`endif

    // Glyphs packed as five octal digits, row 0 in the top digit, MSB = column 0.
    function automatic logic [2:0] font_row(input logic [3:0] dig, input logic [2:0] row);
        logic [14:0] g;
        logic [2:0]  bits;
        g = 15'o00000;
        case (dig)
            4'd0: g = 15'o75557;
            4'd1: g = 15'o26227;
            4'd2: g = 15'o71747;
            4'd3: g = 15'o71717;
            4'd4: g = 15'o55711;
            4'd5: g = 15'o74717;
            4'd6: g = 15'o74757;
            4'd7: g = 15'o71111;
            4'd8: g = 15'o75757;
            4'd9: g = 15'o75717;
            default: g = 15'o00000;
        endcase
        bits = 3'b000;
        case (row)
            3'd0: bits = g[14:12];
            3'd1: bits = g[11:9];
            3'd2: bits = g[8:6];
            3'd3: bits = g[5:3];
            3'd4: bits = g[2:0];
            default: bits = 3'b000;
        endcase
        return bits;
    endfunction

    logic [15:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= 16'h0000;
        end else if (game_tick) begin
            shadow <= score;
        end
    end

`ifdef SCORE_RENDER_HISCORE_EN
    logic [15:0] hi_q;

    // Live score is compared, so a same-cycle game_tick does not delay the update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 16'h0000;
        end else if (game_over && (score > hi_q)) begin
            hi_q <= score;
        end
    end

    assign hiscore = hi_q;
`else
    logic unused_game_over;
    assign unused_game_over = game_over;
    assign hiscore          = 16'h0000;
`endif

    logic [10:0] rx;
    logic [10:0] ry;
    logic [10:0] row_abs;
    logic        x_ok;
    logic        y_ok;
    logic        in_region_d;
    logic [15:0] src;
    logic [1:0]  digit;
    logic [3:0]  nib_d;
    logic [2:0]  r_d;
    logic [1:0]  c_d;

    assign rx      = {1'b0, hpos} - 11'(X0);
    assign ry      = {1'b0, vpos} - 11'(Y0);
    assign row_abs = ry >> S;
    assign x_ok    = ({1'b0, hpos} >= 11'(X0)) && (rx < FIELD_W);
    assign y_ok    = ({1'b0, vpos} >= 11'(Y0));
    assign digit   = rx[S+2 +: 2];
    assign c_d     = rx[S +: 2];

    always_comb begin
        in_region_d = 1'b0;
        src         = shadow;
        r_d         = row_abs[2:0];
        if (x_ok && y_ok && (ry < LINE_H)) begin
            in_region_d = 1'b1;
        end
`ifdef SCORE_RENDER_HISCORE_EN
        else if (x_ok && y_ok && (ry >= HI_TOP) && (ry < HI_BOT)) begin
            in_region_d = 1'b1;
            src         = hiscore;
            r_d         = 3'(row_abs - 11'd6);
        end
`endif
        nib_d = 4'h0;
        case (digit)
            2'd0: nib_d = src[15:12];
            2'd1: nib_d = src[11:8];
            2'd2: nib_d = src[7:4];
            default: nib_d = src[3:0];
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{rx, row_abs};

    logic       in_region_q;
    logic [3:0] nib_q;
    logic [2:0] r_q;
    logic [1:0] c_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_region_q <= 1'b0;
            nib_q       <= 4'h0;
            r_q         <= 3'd0;
            c_q         <= 2'd0;
        end else begin
            in_region_q <= in_region_d;
            nib_q       <= nib_d;
            r_q         <= r_d;
            c_q         <= c_d;
        end
    end

    logic [2:0] frow;
    logic       font_bit;

    always_comb begin
        frow     = font_row(nib_q, r_q);
        font_bit = 1'b0;
        case (c_q)
            2'd0: font_bit = frow[2];
            2'd1: font_bit = frow[1];
            2'd2: font_bit = frow[0];
            default: font_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_on <= 1'b0;
        end else begin
            pixel_on <= in_region_q && font_bit;
        end
    end

endmodule

// File: tb/tb_score_render.sv
// Randomized and directed checks of score_render against a geometric reference model.
module tb_score_render;

    localparam int X0 = 16;
    localparam int Y0 = 16;
    localparam int S  = 2;
`ifdef SCORE_RENDER_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] score = 16'h0;
    logic        game_tick = 1'b0;
    logic        game_over = 1'b0;
    logic [9:0]  hpos = 10'd0;
    logic [9:0]  vpos = 10'd0;
    logic        pixel_on;
    logic [15:0] hiscore;

    score_render #(.X0(X0), .Y0(Y0), .S(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .score    (score),
        .game_tick(game_tick),
        .game_over(game_over),
        .hpos     (hpos),
        .vpos     (vpos),
        .pixel_on (pixel_on),
        .hiscore  (hiscore)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int FONT [10][5] = '{
        '{7,5,5,5,7}, '{2,6,2,2,7}, '{7,1,7,4,7}, '{7,1,7,1,7}, '{5,5,7,1,1},
        '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,1,1,1}, '{7,5,7,5,7}, '{7,5,7,1,7}
    };

    logic [15:0] sh_m = 16'h0;
    logic [15:0] hi_m = 16'h0;
    logic [15:0] sc_cur = 16'h0;
    bit          he [2];
    bit          hv [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_pixel(int h, int v, logic [15:0] sh, logic [15:0] hs);
        int sc;
        int rx;
        int ry;
        int fx;
        int fy;
        int dg;
        int col;
        int row;
        int nib;
        logic [15:0] val;
        sc = 1 << S;
        rx = h - X0;
        ry = v - Y0;
        if (rx < 0 || ry < 0) return 1'b0;
        fx = rx / sc;
        fy = ry / sc;
        if (fx >= 16) return 1'b0;
        if (fy < 5) begin
            val = sh;
            row = fy;
        end else if (HI_EN && fy >= 6 && fy < 11) begin
            val = hs;
            row = fy - 6;
        end else begin
            return 1'b0;
        end
        dg  = fx / 4;
        col = fx % 4;
        nib = int'((val >> (4 * (3 - dg))) & 16'hF);
        if (col == 3 || nib > 9) return 1'b0;
        return ((FONT[nib][row] >> (2 - col)) & 1) != 0;
    endfunction

    task automatic step(input int h, input int v, input bit tick, input bit over);
        bit          e;
        logic [15:0] hi_now;
        @(posedge clk);
        #1;
        hpos      = 10'(h);
        vpos      = 10'(v);
        game_tick = tick;
        game_over = over;
        score     = sc_cur;
        e      = ref_pixel(h, v, sh_m, hi_m);
        hi_now = hi_m;
        if (tick) sh_m = sc_cur;
        if (HI_EN && over && sc_cur > hi_m) hi_m = sc_cur;
        @(negedge clk);
        if (hv[1]) check("pix_model", {31'b0, pixel_on}, {31'b0, he[1]});
        check("hi_model", {16'b0, hiscore}, {16'b0, hi_now});
        he[1] = he[0];
        hv[1] = hv[0];
        he[0] = e;
        hv[0] = 1'b1;
    endtask

    task automatic probe(input int h, input int v, input bit expv, input string tag);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(h, v, 0, 0);
        step(0, 0, 0, 0);
        check({tag, "_n1"}, {31'b0, pixel_on}, 32'd0);
        step(0, 0, 0, 0);
        check(tag, {31'b0, pixel_on}, {31'b0, expv});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        hpos      = 10'd0;
        vpos      = 10'd0;
        game_tick = 1'b0;
        game_over = 1'b0;
        rst_n     = 1'b0;
        sh_m      = 16'h0;
        hi_m      = 16'h0;
        #2;
        check("rst_pix", {31'b0, pixel_on}, 32'd0);
        check("rst_hi", {16'b0, hiscore}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        he[0] = 1'b0;
        he[1] = 1'b0;
        hv[0] = 1'b1;
        hv[1] = 1'b1;
    endtask

    initial begin
        hv[0] = 1'b0;
        hv[1] = 1'b0;
        he[0] = 1'b0;
        he[1] = 1'b0;
        do_reset();

        for (int v = 0; v < 20; v++)
            for (int h = 0; h < 64; h++)
                step(X0 + h, Y0 + v, 0, 0);
        probe(X0 + 4, Y0 + 4, 1'b0, "zero_centre");
        probe(X0, Y0, 1'b1, "zero_corner");

        sc_cur = 16'h1234;
        step(0, 0, 0, 0);
        probe(X0, Y0, 1'b1, "no_tick_still_zero");
        step(0, 0, 1, 0);
        probe(X0, Y0, 1'b0, "d0_one_col0");
        probe(X0 + 4, Y0, 1'b1, "latency_d0_col1");
        probe(X0 + 16, Y0, 1'b1, "d1_two_col0");
        probe(X0 + 12, Y0, 1'b0, "col3_dark");

        sc_cur = 16'h00A5;
        step(0, 0, 1, 0);
        for (int v = 0; v < 20; v++)
            for (int h = 32; h < 64; h++)
                step(X0 + h, Y0 + v, 0, 0);
        probe(X0 + 32, Y0, 1'b0, "invalid_digit_dark");
        probe(X0 + 48, Y0, 1'b1, "d3_five");
        probe(X0 - 1, Y0, 1'b0, "left_edge");
        probe(X0 + 64, Y0, 1'b0, "right_edge");

        sc_cur = 16'h0150;
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("hi_0150", {16'b0, hiscore}, HI_EN ? 32'h0150 : 32'h0);
        sc_cur = 16'h0099;
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("hi_hold", {16'b0, hiscore}, HI_EN ? 32'h0150 : 32'h0);
        probe(X0 + 20, Y0 + 24, HI_EN, "hi_line_d1");
        for (int v = 20; v < 48; v++)
            for (int h = 0; h < 64; h += 3)
                step(X0 + h, Y0 + v, 0, 0);

        sc_cur = 16'h0200;
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        check("tick_and_over", {16'b0, hiscore}, HI_EN ? 32'h0200 : 32'h0);
        probe(X0 + 16, Y0, 1'b1, "tick_and_over_pix");

        step(X0, Y0, 0, 0);
        step(X0, Y0, 0, 0);
        step(X0, Y0, 0, 0);
        do_reset();
        step(X0, Y0, 0, 0);
        check("post_reset_pix", {31'b0, pixel_on}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 4; k++)
                    sc_cur[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                                   : 4'($urandom_range(0, 9));
            end
            step(X0 - 4 + $urandom_range(0, 75), Y0 - 4 + $urandom_range(0, 56),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
